// File: rtl/cvt_round_sched_if.sv
// Request/response bundle between the lane front-ends and the shared rounding scheduler.
// Requesters use the master modport; the scheduler uses the slave modport.
interface cvt_round_sched_if #(
  parameter int NREQ  = 4,
  parameter int IN_W  = 24,
  parameter int OUT_W = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*IN_W-1:0] req_data;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [OUT_W-1:0]     rsp_data;
  logic                 rsp_sat;
  logic                 busy;

  modport master (
    output req_valid, req_data,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_sat, busy
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_sat, busy
  );
endinterface

// File: rtl/cvt_round_sched.sv
// Round-robin scheduler feeding one pipelined fixed-point to integer rounding unit
// (round half away from zero, then wrap or clamp to OUT_W bits).
module cvt_round_sched #(
  parameter int NREQ  = 4,
  parameter int IN_W  = 24,
  parameter int FRAC  = 8,
  parameter int OUT_W = 8,
  parameter int LAT   = 3,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  cvt_round_sched_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int RW  = IN_W - FRAC + 1;
  localparam int CW  = (RW > OUT_W) ? RW + 1 : OUT_W + 1;

  localparam logic [IN_W:0]         ONE_M  = {{IN_W{1'b0}}, 1'b1};
  localparam logic [IN_W:0]         HALF   = ONE_M << (FRAC - 1);
  localparam logic [RW-1:0]         ONE_R  = {{(RW-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0]  LIM_HI = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CW-1:0]  LIM_LO = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]      OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic [IDW-1:0]              rr_q, rr_d;
  logic [NREQ-1:0]             outst_q, outst_d;
  logic [LAT-1:0]              vld_q, vld_d;
  logic [LAT-1:0][IDW-1:0]     id_q, id_d;
  logic [LAT-1:0][OUT_W-1:0]   dat_q, dat_d;
  logic [LAT-1:0]              sat_q, sat_d;

  logic [NREQ-1:0]  elig_s, grant_s, clr_s;
  logic             found_s, pick_s;
  logic [IDW-1:0]   gid_s;
  int               idx_s;
  logic [IN_W-1:0]  op_s;
  logic [IN_W:0]    sext_s, mag_s, rsum_s;
  logic [RW-1:0]    rmag_s, res_s;
  logic signed [CW-1:0] rext_s;
  logic             hi_s, lo_s, sat_s;
  logic [OUT_W-1:0] out_s;

  // Arbitration: first eligible requester at or after the rr pointer, wrapping.
  always_comb begin
    grant_s = {NREQ{1'b0}};
    found_s = 1'b0;
    pick_s  = 1'b0;
    gid_s   = {IDW{1'b0}};
    idx_s   = 0;
    elig_s  = bus.req_valid & ~outst_q & {NREQ{rst_n}};
    for (int k = 0; k < NREQ; k++) begin
      idx_s          = (int'(rr_q) + k) % NREQ;
      pick_s         = ~found_s & elig_s[idx_s];
      grant_s[idx_s] = pick_s;
      gid_s          = pick_s ? IDW'(idx_s) : gid_s;
      found_s        = found_s | pick_s;
    end
  end

  // Rounding datapath on the granted operand; magnitude kept one bit wider so the most negative input is safe.
  always_comb begin
    op_s   = bus.req_data[int'(gid_s)*IN_W +: IN_W];
    sext_s = {op_s[IN_W-1], op_s};
    mag_s  = op_s[IN_W-1] ? (~sext_s + ONE_M) : sext_s;
    rsum_s = mag_s + HALF;
    rmag_s = rsum_s[IN_W:FRAC];
    res_s  = op_s[IN_W-1] ? (~rmag_s + ONE_R) : rmag_s;
    rext_s = {{(CW-RW){res_s[RW-1]}}, res_s};
    hi_s   = rext_s > LIM_HI;
    lo_s   = rext_s < LIM_LO;
    sat_s  = hi_s | lo_s;
    if ((SAT != 0) && sat_s) begin
      out_s = lo_s ? OUT_MIN : OUT_MAX;
    end else begin
      out_s = rext_s[OUT_W-1:0];
    end
  end

  // Next state: pipeline shift (idle stages carry zeros), outstanding set/clear, pointer advance.
  always_comb begin
    vld_d    = vld_q;
    id_d     = id_q;
    dat_d    = dat_q;
    sat_d    = sat_q;
    vld_d[0] = found_s;
    id_d[0]  = gid_s;
    dat_d[0] = found_s ? out_s : {OUT_W{1'b0}};
    sat_d[0] = found_s & sat_s;
    for (int k = 1; k < LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      id_d[k]  = id_q[k-1];
      dat_d[k] = dat_q[k-1];
      sat_d[k] = sat_q[k-1];
    end
    for (int i = 0; i < NREQ; i++) begin
      clr_s[i] = vld_q[LAT-1] & (id_q[LAT-1] == IDW'(i));
    end
    outst_d = (outst_q | grant_s) & ~clr_s;
    if (found_s) begin
      rr_d = (gid_s == IDW'(NREQ-1)) ? {IDW{1'b0}} : gid_s + IDW'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // State registers; reset drops every in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= {IDW{1'b0}};
      outst_q <= {NREQ{1'b0}};
      vld_q   <= {LAT{1'b0}};
      id_q    <= '0;
      dat_q   <= '0;
      sat_q   <= {LAT{1'b0}};
    end else begin
      rr_q    <= rr_d;
      outst_q <= outst_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      dat_q   <= dat_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.req_ready = grant_s;
  assign bus.rsp_valid = vld_q[LAT-1];
  assign bus.rsp_id    = id_q[LAT-1];
  assign bus.rsp_data  = dat_q[LAT-1];
  assign bus.rsp_sat   = sat_q[LAT-1];
  assign bus.busy      = |vld_q;
endmodule

// File: tb/tb_cvt_round_sched.sv
// Directed bench for cvt_round_sched: a wrapping and a clamping instance share the same stimulus.
module tb_cvt_round_sched;
  localparam int NREQ = 4;
  localparam int IN_W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  cvt_round_sched_if #(.NREQ(4), .IN_W(24), .OUT_W(8)) ifw ();
  cvt_round_sched_if #(.NREQ(4), .IN_W(24), .OUT_W(8)) ifs ();

  assign ifs.req_valid = ifw.req_valid;
  assign ifs.req_data  = ifw.req_data;

  cvt_round_sched #(.NREQ(4), .IN_W(24), .FRAC(8), .OUT_W(8), .LAT(3), .SAT(0))
    dut_w (.clk(clk), .rst_n(rst_n), .bus(ifw.slave));
  cvt_round_sched #(.NREQ(4), .IN_W(24), .FRAC(8), .OUT_W(8), .LAT(3), .SAT(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

  typedef struct {
    logic [23:0] data;
    int          lane;
    logic [7:0]  exp_w;
    logic [7:0]  exp_c;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"},     {28'd0, ifw.req_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, ifw.rsp_valid}, 32'd0);
    chk({tag, "_rsp_id"},    {30'd0, ifw.rsp_id},    32'd0);
    chk({tag, "_rsp_data"},  {24'd0, ifw.rsp_data},  32'd0);
    chk({tag, "_rsp_sat"},   {31'd0, ifw.rsp_sat},   32'd0);
    chk({tag, "_busy"},      {31'd0, ifw.busy},      32'd0);
    chk({tag, "_c_data"},    {24'd0, ifs.rsp_data},  32'd0);
  endtask

  // Called at posedge+1; waits (bounded) until the pipeline is empty.
  task automatic drain();
    int n;
    n = 0;
    while (ifw.busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_idle", {31'd0, ifw.busy}, 32'd0);
  endtask

  // One operand on one lane; measure latency and check both instances.
  task automatic run_vec(input vec_t v, input int vi);
    int n;
    bit got;
    ifw.req_data = '0;
    ifw.req_data[v.lane*IN_W +: IN_W] = v.data;
    ifw.req_valid = 4'b0001 << v.lane;
    @(negedge clk);
    chk($sformatf("v%0d_grant", vi), {28'd0, ifw.req_ready}, 32'd1 << v.lane);
    got = 1'b0;
    n = 0;
    while (!got && n < 8) begin
      @(posedge clk); #1;
      ifw.req_valid = 4'b0000;
      n++;
      @(negedge clk);
      got = ifw.rsp_valid;
    end
    chk($sformatf("v%0d_latency", vi), n, 32'd3);
    chk($sformatf("v%0d_id", vi),      {30'd0, ifw.rsp_id},   v.lane);
    chk($sformatf("v%0d_wrap", vi),    {24'd0, ifw.rsp_data}, {24'd0, v.exp_w});
    chk($sformatf("v%0d_sat", vi),     {31'd0, ifw.rsp_sat},  {31'd0, v.exp_sat});
    chk($sformatf("v%0d_clamp", vi),   {24'd0, ifs.rsp_data}, {24'd0, v.exp_c});
    chk($sformatf("v%0d_csat", vi),    {31'd0, ifs.rsp_sat},  {31'd0, v.exp_sat});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{24'd31603,   0, 8'h7b, 8'h7b, 1'b0};
    vecs[1]  = '{24'd31654,   1, 8'h7c, 8'h7c, 1'b0};
    vecs[2]  = '{-24'sd300,   2, 8'hff, 8'hff, 1'b0};
    vecs[3]  = '{24'd640,     3, 8'h03, 8'h03, 1'b0};
    vecs[4]  = '{-24'sd640,   0, 8'hfd, 8'hfd, 1'b0};
    vecs[5]  = '{24'd76800,   1, 8'h2c, 8'h7f, 1'b1};
    vecs[6]  = '{24'h800000,  2, 8'h00, 8'h80, 1'b1};
    vecs[7]  = '{24'd32640,   3, 8'h80, 8'h7f, 1'b1};
    vecs[8]  = '{24'd32639,   0, 8'h7f, 8'h7f, 1'b0};
    vecs[9]  = '{-24'sd32896, 1, 8'h7f, 8'h80, 1'b1};
    vecs[10] = '{-24'sd32895, 2, 8'h80, 8'h80, 1'b0};
    vecs[11] = '{-24'sd128,   3, 8'hff, 8'hff, 1'b0};
    vecs[12] = '{24'd127,     0, 8'h00, 8'h00, 1'b0};

    ifw.req_valid = 4'b0000;
    ifw.req_data  = '0;

    // Reset state
    #3;
    chk_idle_outputs("in_reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");
    @(posedge clk); #1;

    // All four requesters valid: strict rotation, each blocked during its response cycle
    for (int i = 0; i < NREQ; i++) begin
      ifw.req_data[i*IN_W +: IN_W] = 24'((i + 1) * 256);
    end
    ifw.req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("rr_c%0d_ready", c), {28'd0, ifw.req_ready}, 32'd1 << (c % 4));
      chk($sformatf("rr_c%0d_rsp_valid", c), {31'd0, ifw.rsp_valid}, {31'd0, c >= 3});
      if (c >= 3) begin
        chk($sformatf("rr_c%0d_rsp_id", c), {30'd0, ifw.rsp_id}, (c - 3) % 4);
        chk($sformatf("rr_c%0d_rsp_data", c), {24'd0, ifw.rsp_data}, ((c - 3) % 4) + 1);
      end
      @(posedge clk); #1;
    end
    ifw.req_valid = 4'b0000;
    drain();

    // Arithmetic table
    for (int v = 0; v < 13; v++) begin
      run_vec(vecs[v], v);
    end
    drain();

    // Wrap-around grant: pointer at 3, only req2 valid
    ifw.req_data = '0;
    ifw.req_data[2*IN_W +: IN_W] = 24'd512;
    ifw.req_valid = 4'b0100;
    @(negedge clk);
    chk("setup_ptr_grant", {28'd0, ifw.req_ready}, 32'h4);
    @(posedge clk); #1;
    ifw.req_valid = 4'b0000;
    drain();
    ifw.req_valid = 4'b0100;
    @(negedge clk);
    chk("wrap_grant", {28'd0, ifw.req_ready}, 32'h4);
    @(posedge clk); #1;
    ifw.req_valid = 4'b0000;
    drain();
    ifw.req_valid = 4'b1001;
    @(negedge clk);
    chk("ptr_after_wrap", {28'd0, ifw.req_ready}, 32'h8);
    @(posedge clk); #1;
    ifw.req_valid = 4'b0000;
    drain();

    // Reset with three operations in flight
    ifw.req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    ifw.req_valid = 4'b1000;
    chk("inflight_busy", {31'd0, ifw.busy}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("mid_reset");
    @(posedge clk); @(posedge clk); #1;
    ifw.req_valid = 4'b0000;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("discard_c%0d_rsp_valid", c), {31'd0, ifw.rsp_valid}, 32'd0);
      chk($sformatf("discard_c%0d_busy", c), {31'd0, ifw.busy}, 32'd0);
      @(posedge clk); #1;
    end
    ifw.req_valid = 4'b1010;
    @(negedge clk);
    chk("post_reset_lowest", {28'd0, ifw.req_ready}, 32'h2);
    @(posedge clk); #1;
    ifw.req_valid = 4'b0000;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
